// File: rtl/sign_stream_ctrl.sv
// Sequencer for the Picnic signature assembler: requests one signature, captures it,
// and streams it MSB-first as W-bit words over a valid/ready bus.
module sign_stream_ctrl #(
  parameter int unsigned SIG_W = 37760,
  parameter int unsigned W     = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  output logic             sign_start,
  input  logic             sign_end,
  input  logic [SIG_W-1:0] sigma_i,
  output logic [W-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  localparam int unsigned NWORDS = SIG_W / W;
  localparam int unsigned CntW   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NWORDS - 1);

  typedef enum logic [1:0] {StIdle, StReq, StStream, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [SIG_W-1:0] sig_q, sig_d;

  logic sign_start_q, sign_start_d;
  logic out_valid_q, out_valid_d;
  logic out_last_q, out_last_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic handshake;

  assign handshake = out_valid_q & out_ready;

  // State register; reset outranks abort, which is folded into the next-state logic.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      sign_start_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sign_start_q <= sign_start_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Signature shift register carries no reset: contents are meaningless outside STREAM.
  always_ff @(posedge clk) begin
    sig_q <= sig_d;
  end

  // Next-state and datapath.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sig_d   = sig_q;
    if (abort) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d = StReq;
          end
        end
        StReq: begin
          if (sign_end) begin
            sig_d   = sigma_i;
            cnt_d   = '0;
            state_d = StStream;
          end
        end
        StStream: begin
          if (handshake) begin
            if (cnt_q == LastCnt) begin
              state_d = StDone;
            end else begin
              sig_d = sig_q << W;
              cnt_d = cnt_q + CntW'(1);
            end
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so every port comes straight off a flop.
  always_comb begin
    sign_start_d = (state_d == StReq);
    out_valid_d  = (state_d == StStream);
    out_last_d   = (state_d == StStream) && (cnt_d == LastCnt);
    busy_d       = (state_d != StIdle);
    done_d       = (state_d == StDone);
  end

  assign sign_start = sign_start_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign busy       = busy_q;
  assign done       = done_q;
  // Gate the word so the bus reads zero whenever nothing is being offered.
  assign out_data   = sig_q[SIG_W-1 -: W] & {W{out_valid_q}};

endmodule

// File: tb/tb_sign_stream_ctrl.sv
// Scoreboard bench for sign_stream_ctrl: a W=64 instance for the main scenarios and a
// W=32 instance for the narrow-bus ordering check.
module tb_sign_stream_ctrl;

  localparam int unsigned SIG_W = 37760;
  localparam int unsigned W     = 64;
  localparam int unsigned NW    = SIG_W / W;
  localparam int unsigned NW32  = SIG_W / 32;

  typedef struct {
    logic [63:0] data;
    logic        last;
  } beat_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             sign_end = 1'b0;
  logic [SIG_W-1:0] sigma = '0;
  logic             out_ready = 1'b0;
  logic             sign_start, out_valid, out_last, busy, done;
  logic [W-1:0]     out_data;

  logic             start32 = 1'b0;
  logic             sign_end32 = 1'b0;
  logic [SIG_W-1:0] sigma32 = '0;
  logic             sign_start32, valid32, last32, busy32, done32;
  logic [31:0]      data32;

  int    chk_cnt = 0;
  int    pass_cnt = 0;
  beat_t exp_q[$];

  // Monitor state.
  int          valid_cycles = 0;
  int          beats = 0;
  int          done_cnt = 0;
  int          idx32 = 0;
  int          done32_cnt = 0;
  logic        stalled = 1'b0;
  logic        exp_done_next = 1'b0;
  logic [63:0] held_data = '0;
  logic        held_last = 1'b0;

  // Ready driver state.
  logic        ready_lvl = 1'b1;
  logic        bp_mode = 1'b0;
  logic        use_bp = 1'b0;
  logic [3:0]  bp_pat = 4'b1001;
  int          cyc = 0;
  int          bp_base = 0;
  int          vc_base = 0;
  int          beat_base = 0;

  sign_stream_ctrl #(.SIG_W(SIG_W), .W(W)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .sign_start(sign_start),
    .sign_end  (sign_end),
    .sigma_i   (sigma),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  sign_stream_ctrl #(.SIG_W(SIG_W), .W(32)) u_dut32 (
    .clk       (clk),
    .reset     (reset),
    .start     (start32),
    .abort     (1'b0),
    .sign_start(sign_start32),
    .sign_end  (sign_end32),
    .sigma_i   (sigma32),
    .out_data  (data32),
    .out_valid (valid32),
    .out_ready (1'b1),
    .out_last  (last32),
    .busy      (busy32),
    .done      (done32)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [SIG_W-1:0] make_sig(input int ww, input int off);
    logic [SIG_W-1:0] v;
    v = '0;
    for (int i = 0; i < SIG_W / ww; i++) v = (v << ww) | SIG_W'(i + 1 + off);
    return v;
  endfunction

  // Ready driver: level mode or the 1,0,0,1 pattern aligned to the first valid cycle.
  always @(posedge clk) begin
    int d;
    #2;
    d = cyc - bp_base;
    out_ready = bp_mode ? bp_pat[d[1:0]] : ready_lvl;
    cyc++;
  end

  // Monitor: pops expected beats on each handshake and checks stall stability and done.
  always @(negedge clk) begin
    beat_t e;
    if (reset || abort) begin
      stalled       = 1'b0;
      exp_done_next = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (exp_done_next) begin
        check("done_after_last", done, 1);
        exp_done_next = 1'b0;
      end else if (done) begin
        check("done_unexpected", done, 0);
      end
      if (stalled) begin
        check("stall_valid_held", out_valid, 1);
        check("stall_data_held", out_data, held_data);
        check("stall_last_held", out_last, held_last);
      end
      if (out_valid) begin
        valid_cycles++;
        if (out_ready) begin
          stalled = 1'b0;
          if (exp_q.size() == 0) begin
            check("unexpected_beat_valid", out_valid, 0);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", out_data, e.data);
            check("beat_last", out_last, e.last);
            beats++;
            if (e.last) exp_done_next = 1'b1;
          end
        end else begin
          stalled   = 1'b1;
          held_data = out_data;
          held_last = out_last;
        end
      end else begin
        stalled = 1'b0;
      end
    end
    if (!reset && valid32) begin
      check("w32_data", data32, 64'(idx32 + 1));
      check("w32_last", last32, (idx32 == NW32 - 1));
      idx32++;
    end
    if (!reset && done32) done32_cnt++;
  end

  // Starts one signature; the assembler model answers two cycles after sign_start
  // and then scrambles sigma to prove the capture happened.
  task automatic launch(input int off);
    sigma = make_sig(W, off);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("req_sign_start", sign_start, 1);
    check("req_busy", busy, 1);
    check("req_no_valid", out_valid, 0);
    @(posedge clk); #1;
    check("req_sign_start_hold", sign_start, 1);
    for (int i = 0; i < NW; i++) exp_q.push_back('{data: 64'(i + 1 + off), last: (i == NW - 1)});
    vc_base   = valid_cycles;
    beat_base = beats;
    sign_end  = 1'b1;
    @(posedge clk); #1;
    sign_end = 1'b0;
    sigma    = make_sig(W, off + 7000);
    bp_base  = cyc;
    bp_mode  = use_bp;
    check("cap_sign_start_low", sign_start, 0);
    check("cap_valid", out_valid, 1);
  endtask

  task automatic wait_done(input int budget, input int exp_valid_cycles);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_cnt != d0) break;
    end
    #1;
    check("stream_done_seen", (done_cnt != d0), 1);
    check("busy_dropped", busy, 0);
    check("beat_count", beats - beat_base, NW);
    check("valid_cycles", valid_cycles - vc_base, exp_valid_cycles);
    check("queue_drained", exp_q.size(), 0);
    bp_mode = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sign_start", sign_start, 0);
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_data", out_data, 0);
    reset = 1'b0;

    // Single signature, ready held high.
    use_bp = 1'b0;
    ready_lvl = 1'b1;
    launch(0);
    wait_done(NW + 20, NW);

    // Backpressure 1,0,0,1.
    use_bp = 1'b1;
    launch(100);
    wait_done(3 * NW, 2 * NW);
    use_bp = 1'b0;

    // Abort while beat 300 is on the bus, then a full restart.
    launch(0);
    repeat (300) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    exp_q.delete();
    check("abort_valid", out_valid, 0);
    check("abort_last", out_last, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    repeat (5) @(posedge clk);
    #1 check("abort_idle_busy", busy, 0);
    launch(0);
    wait_done(NW + 20, NW);

    // Reset during REQ; a late sign_end must be ignored.
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("rr_sign_start", sign_start, 1);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    check("rr_sign_start_low", sign_start, 0);
    check("rr_busy_low", busy, 0);
    sign_end = 1'b1;
    repeat (2) @(posedge clk);
    #1 sign_end = 1'b0;
    check("rr_late_end_valid", out_valid, 0);
    check("rr_late_end_busy", busy, 0);

    // Start pulses during STREAM and DONE are ignored.
    launch(0);
    repeat (100) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < NW + 20; i++) begin
      @(negedge clk);
      if (done) begin
        seen  = 1'b1;
        start = 1'b1;
        break;
      end
    end
    @(posedge clk); #1 start = 1'b0;
    check("ign_done_seen", seen, 1);
    check("ign_beats", beats - beat_base, NW);
    check("ign_busy_after_done", busy, 0);
    repeat (4) @(posedge clk);
    #1;
    check("ign_still_idle", busy, 0);
    check("ign_no_sign_start", sign_start, 0);

    // Narrow bus: 1180 beats of 32 bits.
    sigma32 = make_sig(32, 0);
    @(posedge clk); #1 start32 = 1'b1;
    @(posedge clk); #1 start32 = 1'b0;
    @(posedge clk); #1 sign_end32 = 1'b1;
    @(posedge clk); #1 sign_end32 = 1'b0;
    sigma32 = '0;
    repeat (NW32 + 10) @(posedge clk);
    #1;
    check("w32_beats", idx32, NW32);
    check("w32_done", done32_cnt, 1);
    check("w32_busy", busy32, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
